itcm_icb_arbiter: RTL and testbench

//  Shares the single ITCM ICB port between the IFU fetch path (port I) and the LSU (port L).

---
 rtl/itcm_icb_arbiter.sv | 138 +++++++++++++
 tb/tb_itcm_icb_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itcm_icb_arbiter.sv
// ITCM ICB arbiter: shares one ITCM port between IFU fetch and LSU.
// In-order source FIFO routes responses; tracks IFU fetch data hold.
module itcm_icb_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 64,
  parameter int OUTS_DEPTH = 2,
  parameter int STARVE_MAX = 4,
  localparam int MW        = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_cmd_valid,
  output logic          ifu_cmd_ready,
  input  logic [AW-1:0] ifu_cmd_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  output logic          ifu_rsp_err,
  input  logic          lsu_cmd_valid,
  output logic          lsu_cmd_ready,
  input  logic [AW-1:0] lsu_cmd_addr,
  input  logic          lsu_cmd_read,
  input  logic [DW-1:0] lsu_cmd_wdata,
  input  logic [MW-1:0] lsu_cmd_wmask,
  output logic          lsu_rsp_valid,
  input  logic          lsu_rsp_ready,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          lsu_rsp_err,
  output logic          itcm_cmd_valid,
  input  logic          itcm_cmd_ready,
  output logic [AW-1:0] itcm_cmd_addr,
  output logic          itcm_cmd_read,
  output logic [DW-1:0] itcm_cmd_wdata,
  output logic [MW-1:0] itcm_cmd_wmask,
  input  logic          itcm_rsp_valid,
  output logic          itcm_rsp_ready,
  input  logic [DW-1:0] itcm_rsp_rdata,
  input  logic          itcm_rsp_err,
  output logic          itcm_nohold,
  output logic          arb_active
);

  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(OUTS_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(OUTS_DEPTH - 1);
  localparam logic [3:0]    STARV_C = 4'(STARVE_MAX);

  logic          r_fifo [OUTS_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_cnt;
  logic [3:0]    r_starve;
  logic          r_nohold;

  logic w_full;
  logic w_empty;
  logic w_force_ifu;
  logic w_sel_lsu;
  logic w_grant_ok;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_rsp_live;
  logic w_ifu_hs;
  logic w_lsu_hs;

  // Full is judged on the registered count only, so a pop never frees a slot early.
  assign w_full      = (r_cnt == DEPTH_C);
  assign w_empty     = (r_cnt == '0);
  assign w_force_ifu = ifu_cmd_valid & (r_starve == STARV_C);
  assign w_sel_lsu   = lsu_cmd_valid & ~w_force_ifu;
  assign w_grant_ok  = rst_n & ~w_full;

  assign itcm_cmd_valid = w_grant_ok &
    (w_sel_lsu ? lsu_cmd_valid : ifu_cmd_valid);
  assign lsu_cmd_ready  = w_grant_ok & w_sel_lsu & itcm_cmd_ready;
  assign ifu_cmd_ready  = w_grant_ok & ~w_sel_lsu &
    ifu_cmd_valid & itcm_cmd_ready;

  assign itcm_cmd_addr  = w_sel_lsu ? lsu_cmd_addr : ifu_cmd_addr;
  assign itcm_cmd_read  = w_sel_lsu ? lsu_cmd_read : 1'b1;
  assign itcm_cmd_wdata = w_sel_lsu ? lsu_cmd_wdata : '0;
  assign itcm_cmd_wmask = w_sel_lsu ? lsu_cmd_wmask : '0;

  assign w_push   = itcm_cmd_valid & itcm_cmd_ready;
  assign w_ifu_hs = w_push & ~w_sel_lsu;
  assign w_lsu_hs = w_push & w_sel_lsu;
  assign w_head   = r_fifo[r_rptr];

  // A response with nothing outstanding is a protocol error: swallow it.
  assign itcm_rsp_ready = rst_n &
    (w_empty | (w_head ? lsu_rsp_ready : ifu_rsp_ready));
  assign w_rsp_live    = rst_n & itcm_rsp_valid & ~w_empty;
  assign ifu_rsp_valid = w_rsp_live & ~w_head;
  assign lsu_rsp_valid = w_rsp_live & w_head;
  assign w_pop         = w_rsp_live & itcm_rsp_ready;

  assign ifu_rsp_rdata = itcm_rsp_rdata;
  assign lsu_rsp_rdata = itcm_rsp_rdata;
  assign ifu_rsp_err   = itcm_rsp_err;
  assign lsu_rsp_err   = itcm_rsp_err;

  assign itcm_nohold = r_nohold;
  assign arb_active  = rst_n &
    (ifu_cmd_valid | lsu_cmd_valid | ~w_empty);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTS_DEPTH; i++) r_fifo[i] <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      r_nohold <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_sel_lsu;
        r_wptr <= (r_wptr == LAST_C) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop)
        r_rptr <= (r_rptr == LAST_C) ? '0 : r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_ifu_hs || !ifu_cmd_valid)
        r_starve <= '0;
      else if (w_lsu_hs && r_starve != STARV_C)
        r_starve <= r_starve + 4'd1;
      if (w_ifu_hs)
        r_nohold <= 1'b1;
      else if (w_lsu_hs)
        r_nohold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_itcm_icb_arbiter.sv
// Bench for itcm_icb_arbiter: hand vectors, corner sequences and
// random traffic against a queue-based reference model.
module tb_itcm_icb_arbiter;

  localparam int AW = 16;
  localparam int DW = 64;
  localparam int MW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          ifu_cmd_valid, ifu_cmd_ready;
  logic [AW-1:0] ifu_cmd_addr;
  logic          ifu_rsp_valid, ifu_rsp_ready;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          ifu_rsp_err;
  logic          lsu_cmd_valid, lsu_cmd_ready;
  logic [AW-1:0] lsu_cmd_addr;
  logic          lsu_cmd_read;
  logic [DW-1:0] lsu_cmd_wdata;
  logic [MW-1:0] lsu_cmd_wmask;
  logic          lsu_rsp_valid, lsu_rsp_ready;
  logic [DW-1:0] lsu_rsp_rdata;
  logic          lsu_rsp_err;
  logic          itcm_cmd_valid, itcm_cmd_ready;
  logic [AW-1:0] itcm_cmd_addr;
  logic          itcm_cmd_read;
  logic [DW-1:0] itcm_cmd_wdata;
  logic [MW-1:0] itcm_cmd_wmask;
  logic          itcm_rsp_valid, itcm_rsp_ready;
  logic [DW-1:0] itcm_rsp_rdata;
  logic          itcm_rsp_err;
  logic          itcm_nohold, arb_active;

  itcm_icb_arbiter #(
    .AW(AW), .DW(DW), .OUTS_DEPTH(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready),
    .ifu_cmd_addr(ifu_cmd_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_rdata(ifu_rsp_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready),
    .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_read(lsu_cmd_read),
    .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .itcm_cmd_valid(itcm_cmd_valid), .itcm_cmd_ready(itcm_cmd_ready),
    .itcm_cmd_addr(itcm_cmd_addr), .itcm_cmd_read(itcm_cmd_read),
    .itcm_cmd_wdata(itcm_cmd_wdata), .itcm_cmd_wmask(itcm_cmd_wmask),
    .itcm_rsp_valid(itcm_rsp_valid), .itcm_rsp_ready(itcm_rsp_ready),
    .itcm_rsp_rdata(itcm_rsp_rdata), .itcm_rsp_err(itcm_rsp_err),
    .itcm_nohold(itcm_nohold), .arb_active(arb_active)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: queue of outstanding owners (0=IFU, 1=LSU)
  bit mq[$];
  int mstarve;
  bit mnohold;
  bit e_ifu_hs, e_lsu_hs, e_pop;

  typedef struct {
    bit iv; logic [15:0] ia; bit lv, lr, cr, rv;
    logic [63:0] rd; bit irr, lrr;
    bit icr, lcr, cv, crd, irv, lrv, rr, nh, act;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_check();
    bit full, iw, lw, owner, live, rr;
    int sz;
    sz    = mq.size();
    full  = (sz >= 2);
    iw    = !full && ifu_cmd_valid && (!lsu_cmd_valid || mstarve == 4);
    lw    = !full && lsu_cmd_valid && !iw;
    owner = (sz > 0) ? mq[0] : 1'b0;
    rr    = (sz == 0) ? 1'b1 : (owner ? lsu_rsp_ready : ifu_rsp_ready);
    live  = itcm_rsp_valid && (sz > 0);
    if (!rst_n) begin
      iw = 0; lw = 0; rr = 0; live = 0;
    end
    chk("ifu_cmd_ready", ifu_cmd_ready, iw && itcm_cmd_ready);
    chk("lsu_cmd_ready", lsu_cmd_ready, lw && itcm_cmd_ready);
    chk("itcm_cmd_valid", itcm_cmd_valid, iw || lw);
    if (iw) begin
      chk("cmd_addr_i", itcm_cmd_addr, ifu_cmd_addr);
      chk("cmd_read_i", itcm_cmd_read, 1);
      chk("cmd_wdata_i", itcm_cmd_wdata, 0);
      chk("cmd_wmask_i", itcm_cmd_wmask, 0);
    end
    if (lw) begin
      chk("cmd_addr_l", itcm_cmd_addr, lsu_cmd_addr);
      chk("cmd_read_l", itcm_cmd_read, lsu_cmd_read);
      chk("cmd_wdata_l", itcm_cmd_wdata, lsu_cmd_wdata);
      chk("cmd_wmask_l", itcm_cmd_wmask, lsu_cmd_wmask);
    end
    chk("ifu_rsp_valid", ifu_rsp_valid, live && !owner);
    chk("lsu_rsp_valid", lsu_rsp_valid, live && owner);
    chk("itcm_rsp_ready", itcm_rsp_ready, rr);
    chk("ifu_rsp_rdata", ifu_rsp_rdata, itcm_rsp_rdata);
    chk("lsu_rsp_rdata", lsu_rsp_rdata, itcm_rsp_rdata);
    chk("rsp_err", {ifu_rsp_err, lsu_rsp_err}, {2{itcm_rsp_err}});
    chk("itcm_nohold", itcm_nohold, mnohold);
    chk("arb_active", arb_active,
        rst_n && (ifu_cmd_valid || lsu_cmd_valid || sz > 0));
    e_ifu_hs = iw && itcm_cmd_ready;
    e_lsu_hs = lw && itcm_cmd_ready;
    e_pop    = live && rr;
  endtask

  task automatic model_reset();
    mq.delete();
    mstarve = 0;
    mnohold = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (e_pop) void'(mq.pop_front());
      if (e_ifu_hs) mq.push_back(1'b0);
      if (e_lsu_hs) mq.push_back(1'b1);
      if (e_ifu_hs || !ifu_cmd_valid) mstarve = 0;
      else if (e_lsu_hs && mstarve < 4) mstarve++;
      if (e_ifu_hs) mnohold = 1;
      else if (e_lsu_hs) mnohold = 0;
    end
    #1;
  endtask

  task automatic cycle();
    #1;
    model_check();
    tick();
  endtask

  task automatic set_in(bit iv, bit lv, bit lr, bit cr,
                        bit rv, bit irr, bit lrr);
    ifu_cmd_valid  = iv;
    lsu_cmd_valid  = lv;
    lsu_cmd_read   = lr;
    itcm_cmd_ready = cr;
    itcm_rsp_valid = rv;
    ifu_rsp_ready  = irr;
    lsu_rsp_ready  = lrr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 1);
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic push_two();
    set_in(1, 0, 0, 1, 0, 1, 1);
    cycle();
    set_in(0, 1, 1, 1, 0, 1, 1);
    cycle();
  endtask

  initial begin
    rst_n          = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 1);
    ifu_cmd_addr   = 16'h0100;
    lsu_cmd_addr   = 16'h0300;
    lsu_cmd_wdata  = 64'h1122_3344_5566_7788;
    lsu_cmd_wmask  = 8'h0F;
    itcm_rsp_rdata = '0;
    itcm_rsp_err   = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    cycle();
    rst_n = 1'b1;

    // iv ia lv lr cr rv rd irr lrr | icr lcr cv crd irv lrv rr nh act
    tbl[0] = '{0, 16'h0000, 0, 0, 0, 0, 64'h0, 1, 1,
               0, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[1] = '{1, 16'h0100, 0, 0, 1, 0, 64'h0, 1, 1,
               1, 0, 1, 1, 0, 0, 1, 0, 1};
    tbl[2] = '{0, 16'h0000, 0, 0, 0, 1, 64'hA5A5_0100_DEAD_BEEF, 1, 1,
               0, 0, 0, 1, 1, 0, 1, 1, 1};
    tbl[3] = '{1, 16'h0200, 1, 1, 1, 0, 64'h0, 1, 1,
               0, 1, 1, 1, 0, 0, 1, 1, 1};
    tbl[4] = '{0, 16'h0000, 0, 0, 0, 1, 64'h5A5A_0300_CAFE_F00D, 1, 1,
               0, 0, 0, 1, 0, 1, 1, 0, 1};
    tbl[5] = '{0, 16'h0000, 1, 0, 0, 0, 64'h0, 1, 1,
               0, 0, 1, 0, 0, 0, 1, 0, 1};
    tbl[6] = '{0, 16'h0000, 0, 0, 0, 0, 64'h0, 1, 1,
               0, 0, 0, 1, 0, 0, 1, 0, 0};
    foreach (tbl[i]) begin
      set_in(tbl[i].iv, tbl[i].lv, tbl[i].lr, tbl[i].cr,
             tbl[i].rv, tbl[i].irr, tbl[i].lrr);
      ifu_cmd_addr   = tbl[i].ia;
      itcm_rsp_rdata = tbl[i].rd;
      #1;
      model_check();
      chk($sformatf("v%0d_icr", i), ifu_cmd_ready, tbl[i].icr);
      chk($sformatf("v%0d_lcr", i), lsu_cmd_ready, tbl[i].lcr);
      chk($sformatf("v%0d_cv", i), itcm_cmd_valid, tbl[i].cv);
      if (tbl[i].cv)
        chk($sformatf("v%0d_crd", i), itcm_cmd_read, tbl[i].crd);
      chk($sformatf("v%0d_irv", i), ifu_rsp_valid, tbl[i].irv);
      chk($sformatf("v%0d_lrv", i), lsu_rsp_valid, tbl[i].lrv);
      chk($sformatf("v%0d_rr", i), itcm_rsp_ready, tbl[i].rr);
      chk($sformatf("v%0d_nh", i), itcm_nohold, tbl[i].nh);
      chk($sformatf("v%0d_act", i), arb_active, tbl[i].act);
      if (tbl[i].irv)
        chk($sformatf("v%0d_rdata", i), ifu_rsp_rdata, tbl[i].rd);
      tick();
    end

    // starvation: four LSU grants, IFU forced on the fifth
    do_reset();
    set_in(1, 1, 1, 1, 1, 1, 1);
    for (int k = 0; k < 6; k++) begin
      #1;
      model_check();
      if (k < 4) begin
        chk("starve_lsu", lsu_cmd_ready, 1);
        chk("starve_ifu_wait", ifu_cmd_ready, 0);
      end else if (k == 4) begin
        chk("starve_ifu_forced", ifu_cmd_ready, 1);
      end else begin
        chk("starve_cleared", lsu_cmd_ready, 1);
      end
      tick();
    end

    // full, then in-order backpressure, then pop with a new command
    do_reset();
    push_two();
    set_in(1, 1, 1, 1, 0, 1, 1);
    #1;
    model_check();
    chk("full_icr", ifu_cmd_ready, 0);
    chk("full_lcr", lsu_cmd_ready, 0);
    chk("full_cv", itcm_cmd_valid, 0);
    tick();
    set_in(0, 0, 0, 1, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      model_check();
      chk("bp_rsp_ready", itcm_rsp_ready, 0);
      chk("bp_ifu_valid", ifu_rsp_valid, 1);
      chk("bp_lsu_wait", lsu_rsp_valid, 0);
      tick();
    end
    set_in(0, 1, 1, 1, 1, 1, 1);
    #1;
    model_check();
    chk("full_pop_held", lsu_cmd_ready, 0);
    chk("full_pop_rr", itcm_rsp_ready, 1);
    tick();
    #1;
    model_check();
    chk("full_after_pop", lsu_cmd_ready, 1);
    chk("order_lsu_rsp", lsu_rsp_valid, 1);
    tick();
    set_in(0, 0, 0, 0, 1, 1, 1);
    cycle();

    // reset with two outstanding, then a stray response
    do_reset();
    push_two();
    rst_n = 1'b0;
    set_in(1, 1, 1, 1, 1, 1, 1);
    #1;
    model_check();
    chk("rst_icr", ifu_cmd_ready, 0);
    chk("rst_lcr", lsu_cmd_ready, 0);
    chk("rst_cv", itcm_cmd_valid, 0);
    chk("rst_rsp", {ifu_rsp_valid, lsu_rsp_valid, itcm_rsp_ready}, 0);
    tick();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 1, 1, 1);
    #1;
    model_check();
    chk("drop_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    chk("drop_rr", itcm_rsp_ready, 1);
    chk("rst_nohold", itcm_nohold, 0);
    chk("rst_active", arb_active, 0);
    tick();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      set_in($urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0);
      ifu_cmd_addr   = 16'($urandom);
      lsu_cmd_addr   = 16'($urandom);
      lsu_cmd_wdata  = {$urandom, $urandom};
      lsu_cmd_wmask  = 8'($urandom);
      itcm_rsp_rdata = {$urandom, $urandom};
      itcm_rsp_err   = $urandom_range(0, 1);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
